// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and helpers for the edge event arbiter slice.
package edge_evt_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Channel index width; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Valid/ready event port between the arbiter (master) and the event consumer (slave).
interface edge_event_arbiter_if
  import edge_evt_pkg::*;
#(
  parameter int N_CH = 4
);

  localparam int CH_W = ch_w(N_CH);

  logic            evt_valid;
  logic [CH_W-1:0] evt_ch;
  logic            evt_ready;

  modport master (
    output evt_valid,
    output evt_ch,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_ch,
    output evt_ready
  );

endinterface

// File: rtl/edge_event_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_arbiter
  import edge_evt_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CH_W = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] gnt_idx,
  output logic            any_req
);

  assign any_req = |req;

  // Scan from the farthest offset down so the nearest requester to ptr wins last.
  always_comb begin
    gnt_idx = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (req[idx]) gnt_idx = CH_W'(idx);
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Rising-edge detector per channel with pending/overflow tracking and a
// round-robin serialiser onto a single valid/ready event port.
//
// state | meaning
// IDLE  | no event offered; waiting for any enabled pending channel
// OFFER | evt_valid high, evt_ch frozen until the consumer accepts
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CH_W = ch_w(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      in,
  input  logic [N_CH-1:0]      ch_en,
  output logic [N_CH-1:0]      ovf,
  input  logic                 ovf_clr,
  edge_event_arbiter_if.master evt
);

  state_t          state;
  logic [N_CH-1:0] h0;
  logic [N_CH-1:0] h1;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] hs_vec;
  logic [N_CH-1:0] arb_req;
  logic [CH_W-1:0] arb_ptr;
  logic [CH_W-1:0] gnt_idx;
  logic            any_req;
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] ch_q;
  logic [CH_W-1:0] ch_next;
  logic            valid_q;
  logic            hs;

  assign rise    = h0 & ~h1;
  assign hs      = valid_q & evt.evt_ready;
  assign ch_next = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;

  assign evt.evt_valid = valid_q;
  assign evt.evt_ch    = ch_q;

  // One-hot of the channel being accepted this cycle.
  always_comb begin
    hs_vec = '0;
    if (hs) hs_vec[ch_q] = 1'b1;
  end

  // While offering, look ahead past the accepted channel so a grant is ready on handshake.
  always_comb begin
    if (state == OFFER) begin
      arb_req = pending & ch_en & ~hs_vec;
      arb_ptr = ch_next;
    end else begin
      arb_req = pending & ch_en;
      arb_ptr = ptr;
    end
  end

  rr_arbiter #(.N_CH(N_CH)) u_rr_arbiter (
    .req     (arb_req),
    .ptr     (arb_ptr),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  // Edge history, pending events and sticky overflow; reset preloads history to avoid a false edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      h0      <= in;
      h1      <= in;
      pending <= '0;
      ovf     <= '0;
    end else begin
      h0      <= in;
      h1      <= h0;
      pending <= ch_en & ((pending & ~hs_vec) | rise);
      ovf     <= (rise & ch_en & pending & ~hs_vec) | (ovf & ~{N_CH{ovf_clr}});
    end
  end

  // Offer FSM with registered valid/channel; pointer advances past each accepted channel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      ch_q    <= '0;
      ptr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state   <= OFFER;
            valid_q <= 1'b1;
            ch_q    <= gnt_idx;
          end
        end
        OFFER: begin
          if (hs) begin
            ptr <= ch_next;
            if (any_req) begin
              ch_q <= gnt_idx;
            end else begin
              state   <= IDLE;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter: a behavioural model predicts each
// offered channel, a negedge monitor compares what the DUT presents.
module tb_edge_event_arbiter;
  import edge_evt_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in_v;
  logic [N-1:0] en_v;
  logic [N-1:0] ovf;
  logic         clr;

  edge_event_arbiter_if #(.N_CH(N)) evt_if ();

  edge_event_arbiter #(.N_CH(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in_v),
    .ch_en   (en_v),
    .ovf     (ovf),
    .ovf_clr (clr),
    .evt     (evt_if.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  // reference model state
  bit [N-1:0] mh0, mh1, mpend, movf;
  bit         mvalid = 1'b0;
  int         mch = 0;
  int         mptr = 0;

  function automatic int pick(bit [N-1:0] req, int start);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (start + k) % N;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  // Behavioural model: advance one clock using the inputs present at this edge.
  always @(posedge clk) begin
    bit [N-1:0] rise, npend, novf, req;
    bit         hs, others;
    int         acc, g;
    if (!rst) begin
      mh0 = in_v; mh1 = in_v; mpend = '0; movf = '0;
      mvalid = 1'b0; mch = 0; mptr = 0;
    end else begin
      rise = mh0 & ~mh1;
      hs   = mvalid && (evt_if.evt_ready === 1'b1);
      acc  = hs ? mch : -1;
      for (int i = 0; i < N; i++) begin
        others   = mpend[i] && (i != acc);
        npend[i] = en_v[i] && (others || rise[i]);
        novf[i]  = (rise[i] && en_v[i] && others) || (movf[i] && !clr);
      end
      if (!mvalid) begin
        g = pick(mpend & en_v, mptr);
        if (g >= 0) begin
          mvalid = 1'b1; mch = g; exp_q.push_back(g);
        end
      end else if (hs) begin
        mptr = (mch + 1) % N;
        req = mpend & en_v;
        req[mch] = 1'b0;
        g = pick(req, mptr);
        if (g >= 0) begin
          mch = g; exp_q.push_back(g);
        end else begin
          mvalid = 1'b0;
        end
      end
      mpend = npend; movf = novf; mh1 = mh0; mh0 = in_v;
    end
  end

  // Monitor: compare DUT outputs with the model and pop expected channels at each new offer.
  bit       prev_valid = 1'b0;
  bit       prev_ready = 1'b0;
  int       held_ch = 0;
  always @(negedge clk) begin
    int exp_ch;
    checks++;
    if (evt_if.evt_valid !== mvalid) begin
      errors++;
      $display("FAIL valid: got %b expected %b at %0t", evt_if.evt_valid, mvalid, $time);
    end
    checks++;
    if (ovf !== movf) begin
      errors++;
      $display("FAIL ovf: got %b expected %b at %0t", ovf, movf, $time);
    end
    if (evt_if.evt_valid === 1'b1) begin
      checks++;
      if (!prev_valid || prev_ready) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL offer_unexpected: got ch %0d expected none at %0t", evt_if.evt_ch, $time);
        end else begin
          exp_ch = exp_q.pop_front();
          if (int'(evt_if.evt_ch) != exp_ch) begin
            errors++;
            $display("FAIL offer_ch: got %0d expected %0d at %0t", evt_if.evt_ch, exp_ch, $time);
          end
        end
      end else if (int'(evt_if.evt_ch) != held_ch) begin
        errors++;
        $display("FAIL offer_hold: got %0d expected %0d at %0t", evt_if.evt_ch, held_ch, $time);
      end
    end
    prev_valid = (evt_if.evt_valid === 1'b1);
    prev_ready = (evt_if.evt_ready === 1'b1);
    held_ch    = int'(evt_if.evt_ch);
  end

  initial begin
    rst = 1'b0; in_v = 4'b1111; en_v = 4'b1111; clr = 1'b0;
    evt_if.evt_ready = 1'b1;
    tick(3);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("reset_quiet_valid", int'(evt_if.evt_valid), 0);
      chk("reset_quiet_ovf", int'(ovf), 0);
    end

    // single edge on ch2: offered two edges later for exactly one cycle
    in_v = 4'b0000; tick(3);
    in_v = 4'b0100;
    tick(); chk("lat_k", int'(evt_if.evt_valid), 0);
    tick(); chk("lat_k1", int'(evt_if.evt_valid), 0);
    tick(); chk("lat_k2_valid", int'(evt_if.evt_valid), 1);
    chk("lat_k2_ch", int'(evt_if.evt_ch), 2);
    tick(); chk("lat_one_cycle", int'(evt_if.evt_valid), 0);

    // fairness burst from pointer 0
    in_v = 4'b0000; rst = 1'b0; tick(); rst = 1'b1; tick(2);
    in_v = 4'b1111; tick(3);
    for (int c = 0; c < N; c++) begin
      chk("burst0_valid", int'(evt_if.evt_valid), 1);
      chk("burst0_ch", int'(evt_if.evt_ch), c);
      tick();
    end
    chk("burst0_end", int'(evt_if.evt_valid), 0);

    // move pointer to 2 with a ch1 event, then burst again
    in_v = 4'b0000; tick(2);
    in_v = 4'b0010; tick(4);
    in_v = 4'b0000; tick(2);
    in_v = 4'b1111; tick(3);
    for (int c = 0; c < N; c++) begin
      chk("burst2_ch", int'(evt_if.evt_ch), (2 + c) % N);
      tick();
    end
    chk("burst2_end", int'(evt_if.evt_valid), 0);

    // backpressure on ch1, re-rise sets ovf[1], ovf_clr clears it
    evt_if.evt_ready = 1'b0;
    in_v = 4'b0000; tick(2);
    in_v = 4'b0010; tick(3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", int'(evt_if.evt_valid), 1);
      chk("bp_ch", int'(evt_if.evt_ch), 1);
      tick();
    end
    in_v = 4'b0000; tick();
    in_v = 4'b0010; tick(2);
    chk("bp_ovf_set", int'(ovf), 2);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("bp_ovf_clr", int'(ovf), 0);
    evt_if.evt_ready = 1'b1; tick();
    chk("bp_drain", int'(evt_if.evt_valid), 0);
    tick(2);

    // disabled ch3 toggling
    en_v = 4'b0111;
    for (int i = 0; i < 6; i++) begin
      in_v[3] = ~in_v[3];
      tick();
      chk("en_off_valid", int'(evt_if.evt_valid), 0);
    end
    chk("en_off_ovf", int'(ovf), 0);

    // pending ch3 dropped by ch_en while ch1 is offered
    en_v = 4'b1111; in_v = 4'b0000; tick(2);
    evt_if.evt_ready = 1'b0;
    in_v = 4'b0010; tick(3);
    in_v = 4'b1010; tick(3);
    en_v = 4'b0111; tick();
    en_v = 4'b1111; evt_if.evt_ready = 1'b1; tick();
    chk("en_drop_idle", int'(evt_if.evt_valid), 0);
    tick();
    chk("en_drop_none", int'(evt_if.evt_valid), 0);

    // accept on ch0 coinciding with a new ch0 rise
    evt_if.evt_ready = 1'b0;
    in_v = 4'b0000; tick(2);
    in_v = 4'b0001; tick(3);
    in_v = 4'b0000; tick(2);
    in_v = 4'b0001; tick();
    evt_if.evt_ready = 1'b1; tick();
    chk("reedge_gap", int'(evt_if.evt_valid), 0);
    chk("reedge_ovf", int'(ovf), 0);
    tick();
    chk("reedge_valid", int'(evt_if.evt_valid), 1);
    chk("reedge_ch", int'(evt_if.evt_ch), 0);
    tick(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_v = 4'($urandom);
      en_v = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b1111;
      evt_if.evt_ready = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst = 1'b1; clr = 1'b0; evt_if.evt_ready = 1'b1;
    tick(12);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
